bar_mover: RTL and testbench

Drawing/motion stage fed by `frame_counter`. It owns one moving bar of blocks on the current stacking row and turns each movement tick into a pixel-by-pixel erase, a one-column shift and a pixel-by-pixel redraw, driving the VGA adapter's plot port. When the player presses stop, it freezes the bar and reports the final column to the game controller.

---
 rtl/bar_mover.sv | 188 ++++++++++++++++++
 tb/tb_bar_mover.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_mover.sv
// bar_mover: owns one moving bar on the current stacking row, erasing, shifting and
// redrawing it pixel by pixel through the VGA plot port; freezes it on player stop.
module bar_mover #(
    parameter int CELL = 4,
    parameter int COLS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] row,
    input  logic [3:0] bar_len,
    input  logic [2:0] colour,
    input  logic       step,
    input  logic       stop,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic [4:0] pos
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_MOVE,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [4:0] r_row;
    logic [4:0] r_len;
    logic [2:0] r_colour;
    logic [4:0] r_pos;
    logic       r_dir_left;
    logic       r_pending;
    logic       r_step_d;
    logic [7:0] r_px;
    logic [6:0] r_py;

    // First pipeline stage of the pixel path; the output registers form the second.
    logic       r_s1_plot;
    logic [7:0] r_s1_x;
    logic [6:0] r_s1_y;
    logic [2:0] r_s1_colour;

    logic       w_step_edge;
    logic       w_scanning;
    logic [7:0] w_px_last;
    logic       w_px_wrap;
    logic       w_scan_last;
    logic       w_at_right;
    logic [4:0] w_len_clamped;

    assign w_step_edge = step & ~r_step_d;
    assign w_scanning  = (r_state == S_DRAW) || (r_state == S_ERASE);
    assign w_px_last   = 8'(int'(r_len) * CELL - 1);
    assign w_px_wrap   = (r_px == w_px_last);
    assign w_scan_last = w_px_wrap && (r_py == 7'(CELL - 1));
    assign w_at_right  = (int'(r_pos) + int'(r_len) == COLS);
    assign pos         = r_pos;

    always_comb begin
        if (bar_len == 4'd0) begin
            w_len_clamped = 5'd1;
        end else if (int'(bar_len) >= COLS) begin
            w_len_clamped = 5'(COLS - 1);
        end else begin
            w_len_clamped = {1'b0, bar_len};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRAW;
            S_DRAW:  if (w_scan_last) w_next = S_WAIT;
            S_WAIT: begin
                if (stop || r_pending) begin
                    w_next = S_DONE;
                end else if (w_step_edge) begin
                    w_next = S_ERASE;
                end
            end
            S_ERASE: if (w_scan_last) w_next = S_MOVE;
            S_MOVE:  w_next = S_DRAW;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row      <= 5'd0;
            r_len      <= 5'd1;
            r_colour   <= 3'd0;
            r_pos      <= 5'd0;
            r_dir_left <= 1'b0;
            r_pending  <= 1'b0;
            r_step_d   <= 1'b0;
            r_px       <= 8'd0;
            r_py       <= 7'd0;
        end else begin
            r_step_d <= step;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row      <= row;
                        r_len      <= w_len_clamped;
                        r_colour   <= colour;
                        r_pos      <= 5'd0;
                        r_dir_left <= 1'b0;
                        r_px       <= 8'd0;
                        r_py       <= 7'd0;
                    end
                end
                S_DRAW, S_ERASE: begin
                    if (stop) r_pending <= 1'b1;
                    // Counters wrap to zero after the last pixel, ready for the next scan.
                    if (w_px_wrap) begin
                        r_px <= 8'd0;
                        r_py <= w_scan_last ? 7'd0 : r_py + 7'd1;
                    end else begin
                        r_px <= r_px + 8'd1;
                    end
                end
                S_MOVE: begin
                    if (stop) r_pending <= 1'b1;
                    if (!r_dir_left && w_at_right) begin
                        r_dir_left <= 1'b1;
                        r_pos      <= r_pos - 5'd1;
                    end else if (r_dir_left && (r_pos == 5'd0)) begin
                        r_dir_left <= 1'b0;
                        r_pos      <= r_pos + 5'd1;
                    end else if (r_dir_left) begin
                        r_pos <= r_pos - 5'd1;
                    end else begin
                        r_pos <= r_pos + 5'd1;
                    end
                end
                S_DONE: r_pending <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_plot   <= 1'b0;
            r_s1_x      <= 8'd0;
            r_s1_y      <= 7'd0;
            r_s1_colour <= 3'd0;
            plot        <= 1'b0;
            x           <= 8'd0;
            y           <= 7'd0;
            colour_out  <= 3'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_s1_plot   <= w_scanning;
            r_s1_x      <= 8'(int'(r_pos) * CELL + int'(r_px));
            r_s1_y      <= 7'(int'(r_row) * CELL + int'(r_py));
            r_s1_colour <= (r_state == S_ERASE) ? 3'b000 : r_colour;
            plot        <= r_s1_plot;
            x           <= r_s1_x;
            y           <= r_s1_y;
            colour_out  <= r_s1_colour;
            busy        <= (r_state != S_IDLE);
            done        <= (r_state == S_DONE);
        end
    end

endmodule

// File: tb/tb_bar_mover.sv
// Directed bench for bar_mover: logs every plotted pixel at the falling edge and
// compares scans, timing and bar position against hand-computed expectations.
module tb_bar_mover;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] row;
    logic [3:0] bar_len;
    logic [2:0] colour;
    logic       step;
    logic       stop;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;
    logic [4:0] pos;

    bar_mover #(.CELL(4), .COLS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .row        (row),
        .bar_len    (bar_len),
        .colour     (colour),
        .step       (step),
        .stop       (stop),
        .x          (x),
        .y          (y),
        .colour_out (colour_out),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .pos        (pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int px;
        int py;
        int c;
    } pix_t;

    pix_t plog[$];
    int   cyc       = 0;
    int   n_done    = 0;
    int   last_done = -1;
    int   n_checks  = 0;
    int   n_fail    = 0;

    // Falling-edge monitor: cyc equals the index of the rising edge just passed.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (plot) plog.push_back('{cyc, int'(x), int'(y), int'(colour_out)});
        if (done) begin
            n_done    = n_done + 1;
            last_done = cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start(input int r, input int l, input int c);
        row     = 5'(r);
        bar_len = 4'(l);
        colour  = 3'(c);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic do_step(input int n);
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_cycles(n);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Expected scan: px inner over len*4, py outer over 4, consecutive cycles.
    task automatic check_scan(input string tag, input int base, input int p, input int r,
                              input int len, input int col);
        int   n;
        int   w;
        int   bad;
        int   gaps;
        pix_t e;
        n    = len * 16;
        w    = len * 4;
        bad  = 0;
        gaps = 0;
        for (int i = 0; i < n; i++) begin
            if (base + i >= plog.size()) begin
                bad++;
            end else begin
                e = plog[base + i];
                if (e.px != p * 4 + i % w || e.py != r * 4 + i / w || e.c != col) bad++;
                if (i > 0 && e.cyc != plog[base + i - 1].cyc + 1) gaps++;
            end
        end
        check({tag, "_pix"}, bad, 0);
        check({tag, "_gap"}, gaps, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int m;
        int d0;

        reset = 1'b1; start = 1'b0; row = '0; bar_len = '0;
        colour = '0; step = 1'b0; stop = 1'b0;
        wait_cycles(2);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pos", pos, 0);
        check("rst_x", x, 0);
        reset = 1'b0;
        wait_cycles(3);

        // Start and draw.
        k = cyc + 1;
        pulse_start(3, 3, 4);
        check("busy_at_k", busy, 0);
        tick();
        check("busy_at_k1", busy, 1);
        wait_cycles(60);
        check("draw_count", plog.size(), 48);
        if (plog.size() > 0) check("draw_first_cyc", plog[0].cyc, k + 2);
        check_scan("draw0", 0, 0, 3, 3, 4);
        check("busy_wait", busy, 1);
        wait_cycles(40);
        check("wait_no_plot", plog.size(), 48);

        // Single step: erase, one idle cycle, redraw one column right.
        plog.delete();
        m = cyc + 1;
        do_step(110);
        check("step_count", plog.size(), 96);
        if (plog.size() == 96) begin
            check("erase_first_cyc", plog[0].cyc, m + 2);
            check("erase_last_cyc", plog[47].cyc, m + 49);
            check("redraw_first_cyc", plog[48].cyc, m + 51);
        end
        check_scan("erase1", 0, 0, 3, 3, 0);
        check_scan("redraw1", 48, 1, 3, 3, 4);
        check("pos_after_step", pos, 1);

        // Bounce at the right wall, then the left wall.
        repeat (11) do_step(105);
        plog.delete();
        do_step(105);
        check("pos_right_wall", pos, 13);
        check_scan("draw13", 48, 13, 3, 3, 4);
        do_step(105);
        check("pos_bounce_left", pos, 12);
        repeat (12) do_step(105);
        check("pos_left_wall", pos, 0);
        do_step(105);
        check("pos_bounce_right", pos, 1);

        // Stop wins over a simultaneous step edge.
        plog.delete();
        d0 = n_done;
        stop = 1'b1;
        step = 1'b1;
        tick();
        stop = 1'b0;
        step = 1'b0;
        check("stopprio_done_m", done, 0);
        tick();
        check("stopprio_done_m1", done, 1);
        check("stopprio_busy_m1", busy, 1);
        tick();
        check("stopprio_busy_m2", busy, 0);
        check("stopprio_done_m2", done, 0);
        wait_cycles(60);
        check("stopprio_plots", plog.size(), 0);
        check("stopprio_pos", pos, 1);
        check("stopprio_ndone", n_done - d0, 1);

        // Stop during erase: move and redraw complete, then freeze.
        pulse_start(5, 3, 2);
        wait_cycles(60);
        check("start_resets_pos", pos, 0);
        plog.delete();
        d0 = n_done;
        do_step(10);
        pulse_stop();
        wait_cycles(140);
        check("stoperase_count", plog.size(), 96);
        check_scan("stoperase_redraw", 48, 1, 5, 3, 2);
        check("stoperase_pos", pos, 1);
        check("stoperase_ndone", n_done - d0, 1);
        if (plog.size() == 96) check("stoperase_done_cyc", last_done, plog[95].cyc + 1);
        check("stoperase_busy", busy, 0);

        // Step held high: exactly one move.
        pulse_start(0, 3, 1);
        wait_cycles(60);
        plog.delete();
        step = 1'b1;
        wait_cycles(1000);
        step = 1'b0;
        wait_cycles(20);
        check("held_step_count", plog.size(), 96);
        check("held_step_pos", pos, 1);
        pulse_stop();
        wait_cycles(5);
        check("held_step_idle", busy, 0);

        // bar_len=0 clamps to one cell; bottom row.
        plog.delete();
        pulse_start(29, 0, 7);
        wait_cycles(40);
        check("len0_count", plog.size(), 16);
        check_scan("len0", 0, 0, 29, 1, 7);
        pulse_stop();
        wait_cycles(5);

        // Longest bar bounces after a single move each way.
        plog.delete();
        pulse_start(1, 15, 3);
        wait_cycles(260);
        check("len15_count", plog.size(), 240);
        check_scan("len15", 0, 0, 1, 15, 3);
        do_step(500);
        check("len15_pos1", pos, 1);
        do_step(500);
        check("len15_pos0", pos, 0);
        do_step(500);
        check("len15_pos1b", pos, 1);
        pulse_stop();
        wait_cycles(5);

        // Reset in the middle of a draw.
        pulse_start(3, 3, 6);
        wait_cycles(10);
        check("middraw_plot", plot, 1);
        reset = 1'b1;
        #1;
        check("midrst_plot", plot, 0);
        check("midrst_busy", busy, 0);
        check("midrst_x", x, 0);
        check("midrst_y", y, 0);
        check("midrst_colour", colour_out, 0);
        plog.delete();
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(5);
        check("midrst_no_plot", plog.size(), 0);
        pulse_start(2, 2, 5);
        wait_cycles(50);
        check("rst_redraw_count", plog.size(), 32);
        check_scan("rst_redraw", 0, 0, 2, 2, 5);
        check("rst_redraw_pos", pos, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
